// File: rtl/prbs15_pkg.sv
// Shared PRBS15 (x^15 + x^14 + 1) definitions: LFSR length, checker states and the
// multi-step advance used by the generator and the checker.
package prbs15_pkg;

  localparam int unsigned PRBS15_LEN = 15;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} prbs15_chk_state_t;

  // Advance the LFSR 'steps' times (0..PRBS15_LEN), shifting the LSB out each step.
  function automatic logic [PRBS15_LEN-1:0] prbs15_advance(input logic [PRBS15_LEN-1:0] state,
                                                           input int unsigned steps);
    logic [PRBS15_LEN-1:0] s;
    s = state;
    for (int unsigned i = 0; i < PRBS15_LEN; i++) begin
      if (i < steps) s = {s[1] ^ s[0], s[PRBS15_LEN-1:1]};
    end
    return s;
  endfunction

endpackage

// File: rtl/prbs15_checker_if.sv
// Data/status bundle between a PRBS15 word source and prbs15_checker.
interface prbs15_checker_if
  import prbs15_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) ();

  logic                  dis;
  logic                  din_valid;
  logic [PRBS15_LEN-1:0] din;
  logic                  clr_cnt;
  logic                  locked;
  logic                  err_word;
  logic [CNT_W-1:0]      err_cnt;

  modport master (
    output dis, din_valid, din, clr_cnt,
    input  locked, err_word, err_cnt
  );

  modport slave (
    input  dis, din_valid, din, clr_cnt,
    output locked, err_word, err_cnt
  );

endinterface

// File: rtl/prbs15_step.sv
// Combinational PRBS15 word advance: cur moved WORDWIDTH LFSR steps forward.
module prbs15_step
  import prbs15_pkg::*;
#(
  parameter int unsigned WORDWIDTH = 15
) (
  input  logic [PRBS15_LEN-1:0] cur,
  output logic [PRBS15_LEN-1:0] nxt
);

  assign nxt = prbs15_advance(cur, WORDWIDTH);

endmodule

// File: rtl/prbs15_checker.sv
// Self-synchronising PRBS15 word checker with lock tracking and saturating error count.
// Define PRBS15_BITERR_CNT_EN to count bit errors (popcount) instead of word errors.
module prbs15_checker
  import prbs15_pkg::*;
#(
  parameter int unsigned WORDWIDTH  = 15,
  parameter int unsigned LOCK_WORDS = 4,
  parameter int unsigned LOSS_WORDS = 8,
  parameter int unsigned CNT_W      = 16
) (
  input logic             clk,
  input logic             reset,
  prbs15_checker_if.slave bus
);

  localparam int unsigned GoodW = $clog2(LOCK_WORDS + 1);
  localparam int unsigned BadW  = $clog2(LOSS_WORDS + 1);

  prbs15_chk_state_t     state_q, state_d;
  logic [PRBS15_LEN-1:0] exp_q, exp_d;
  logic [GoodW-1:0]      good_q, good_d;
  logic [BadW-1:0]       bad_q, bad_d;
  logic                  locked_q;
  logic                  err_word_q, err_word_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;

  logic [PRBS15_LEN-1:0] adv_exp, adv_din;
  logic                  fire, din_zero, mismatch, err, good_last, bad_last;
  logic [4:0]            incr;
  logic [CNT_W-1:0]      cnt_base, cnt_sat;
  logic [CNT_W:0]        cnt_sum;

  prbs15_step #(.WORDWIDTH(WORDWIDTH)) u_step_exp (.cur(exp_q),   .nxt(adv_exp));
  prbs15_step #(.WORDWIDTH(WORDWIDTH)) u_step_din (.cur(bus.din), .nxt(adv_din));

  assign fire      = !bus.dis && bus.din_valid;
  assign din_zero  = (bus.din == '0);
  assign mismatch  = (bus.din != exp_q);
  assign err       = fire && (state_q == LOCKED) && mismatch;
  assign good_last = (32'(good_q) == LOCK_WORDS - 1);
  assign bad_last  = (32'(bad_q) == LOSS_WORDS - 1);

`ifdef PRBS15_BITERR_CNT_EN
  always_comb begin
    incr = '0;
    for (int i = 0; i < PRBS15_LEN; i++) incr = incr + 5'(bus.din[i] ^ exp_q[i]);
  end
`else
  assign incr = 5'd1;
`endif

  // A clear concurrent with an error restarts the count from this word's increment.
  assign cnt_base = bus.clr_cnt ? '0 : err_cnt_q;
  assign cnt_sum  = {1'b0, cnt_base} + (CNT_W + 1)'(incr);
  assign cnt_sat  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset) state_q <= SEARCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (fire) begin
      case (state_q)
        SEARCH:  if (!din_zero) state_d = VERIFY;
        VERIFY: begin
          if (!mismatch) begin
            if (good_last) state_d = LOCKED;
          end else if (din_zero) begin
            state_d = SEARCH;
          end
        end
        LOCKED:  if (mismatch && bad_last) state_d = SEARCH;
        default: state_d = SEARCH;
      endcase
    end
  end

  always_comb begin
    exp_d      = exp_q;
    good_d     = good_q;
    bad_d      = bad_q;
    err_cnt_d  = err_cnt_q;
    err_word_d = err_word_q;
    if (!bus.dis) err_word_d = err;
    if (fire) begin
      case (state_q)
        SEARCH: begin
          if (!din_zero) begin
            exp_d  = adv_din;
            good_d = '0;
          end
        end
        VERIFY: begin
          if (!mismatch) begin
            exp_d  = adv_exp;
            good_d = good_last ? '0 : good_q + 1'b1;
          end else begin
            exp_d  = adv_din;
            good_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: once locked, exp never re-seeds from din.
          exp_d = adv_exp;
          if (mismatch) bad_d = bad_last ? '0 : bad_q + 1'b1;
          else          bad_d = '0;
        end
        default: ;
      endcase
      if (bus.clr_cnt) begin
        bad_d     = '0;
        err_cnt_d = '0;
      end
      if (err) err_cnt_d = cnt_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      exp_q      <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      locked_q   <= 1'b0;
      err_word_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      exp_q      <= exp_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      locked_q   <= (state_d == LOCKED);
      err_word_q <= err_word_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.locked   = locked_q;
  assign bus.err_word = err_word_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule
